// File: rtl/fmc_bram_arb_pkg.sv
// Shared types and limits for the FMC / internal-logic BRAM arbiter.
package fmc_bram_arb_pkg;

  // Requester identity, carried with every read down the return pipeline.
  typedef enum logic {
    REQ_FMC = 1'b0,
    REQ_INT = 1'b1
  } req_id_t;

  // One slot of the return pipeline.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rtn_ent_t;

  // Deepest BRAM read latency the return pipeline is meant to cover.
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/fmc_bram_arb_rtn.sv
// Read-return pipeline: tracks which requester owns each in-flight read and
// steers bram_dout to that requester when the read data is valid.
module fmc_bram_arb_rtn
  import fmc_bram_arb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_vld_i,
  input  req_id_t           push_id_i,
  input  logic [DATA_W-1:0] bram_dout_i,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o
);

  // Slot 0 is loaded on the grant edge; slot RD_LAT lines up with bram_dout.
  rtn_ent_t [RD_LAT:0] pipe_q;
  rtn_ent_t [RD_LAT:0] pipe_d;
  rtn_ent_t            push_ent;
  rtn_ent_t            head;

  // Build the entry for this cycle's grant and shift it in at the bottom.
  always_comb begin
    push_ent.valid = push_vld_i;
    push_ent.id    = push_id_i;
    pipe_d         = {pipe_q[RD_LAT-1:0], push_ent};
  end

  // Pipeline register; reset drops every in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign head = pipe_q[RD_LAT];

  // Demux the returning data; the requester not addressed sees zero.
  always_comb begin
    m0_rvalid_o = head.valid && (head.id == REQ_FMC);
    m1_rvalid_o = head.valid && (head.id == REQ_INT);
    m0_rdata_o  = m0_rvalid_o ? bram_dout_i : '0;
    m1_rdata_o  = m1_rvalid_o ? bram_dout_i : '0;
  end

endmodule

// File: rtl/fmc_bram_arb.sv
// Two-requester arbiter sharing one single-port BRAM between the FMC slave
// (requester 0, default priority) and internal logic (requester 1), with a
// starvation bound for requester 1 and the FMC wait output.
module fmc_bram_arb
  import fmc_bram_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W/8-1:0] m0_we,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W/8-1:0] m1_we,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                bram_en,
  output logic [DATA_W/8-1:0] bram_we,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_din,
  input  logic [DATA_W-1:0]   bram_dout,
  output logic                fmc_nwait
);

  localparam int         BE_W       = DATA_W / 8;
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic              req0, req1;
  logic              gnt0, gnt1, gnt_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_we;
  logic [DATA_W-1:0] sel_wdata;

  logic [7:0]        starve_q, starve_d;
  logic              bram_en_q, bram_en_d;
  logic [BE_W-1:0]   bram_we_q, bram_we_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_din_q, bram_din_d;

  // Requests are masked during reset so no command is accepted and then lost;
  // this also keeps fmc_nwait high while reset is asserted.
  assign req0 = m0_req & rst_n;
  assign req1 = m1_req & rst_n;

  // Grant: requester 0 wins unless requester 1 has waited STARVE_MAX cycles.
  always_comb begin
    gnt1      = req1 && (!req0 || (starve_q == STARVE_LIM));
    gnt0      = req0 && !gnt1;
    gnt_any   = gnt0 | gnt1;
    sel_addr  = gnt1 ? m1_addr  : m0_addr;
    sel_we    = gnt1 ? m1_we    : m0_we;
    sel_wdata = gnt1 ? m1_wdata : m0_wdata;
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign fmc_nwait = !(req0 && !gnt0);

  // Starvation counter: counts consecutive denied cycles, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!req1 || gnt1) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // BRAM command next-state: load the winner, otherwise idle with address/data held.
  always_comb begin
    bram_en_d   = gnt_any;
    bram_we_d   = gnt_any ? sel_we    : '0;
    bram_addr_d = gnt_any ? sel_addr  : bram_addr_q;
    bram_din_d  = gnt_any ? sel_wdata : bram_din_q;
  end

  // Control and command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q    <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
    end else begin
      starve_q    <= starve_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
    end
  end

  assign bram_en   = bram_en_q;
  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;

  fmc_bram_arb_rtn #(
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) u_rtn (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_vld_i (gnt_any && (sel_we == '0)),
    .push_id_i  (gnt1 ? REQ_INT : REQ_FMC),
    .bram_dout_i(bram_dout),
    .m0_rvalid_o(m0_rvalid),
    .m0_rdata_o (m0_rdata),
    .m1_rvalid_o(m1_rvalid),
    .m1_rdata_o (m1_rdata)
  );

endmodule

// File: tb/tb_fmc_bram_arb.sv
// Bench for fmc_bram_arb: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model with a BRAM model.
module tb_fmc_bram_arb;
  import fmc_bram_arb_pkg::*;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 16;
  localparam int BE_W       = DATA_W / 8;
  localparam int RD_LAT     = 3;
  localparam int STARVE_MAX = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              m0_req = 1'b0, m1_req = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
  logic [BE_W-1:0]   m0_we = '0, m1_we = '0;
  logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              bram_en;
  logic [BE_W-1:0]   bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din, bram_dout;
  logic              fmc_nwait;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fmc_bram_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout), .fmc_nwait(fmc_nwait)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Power-up contents of every BRAM word that has not been written.
  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return 16'h5A00 ^ {4'h0, a};
  endfunction

  // ---------------- BRAM model (RD_LAT cycles from enable to data) ----------
  bit [DATA_W-1:0]   bmem  [4096];
  bit                bwr   [4096];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin : bram_model
    logic [DATA_W-1:0] w;
    if (bram_en) begin
      w = bwr[bram_addr] ? bmem[bram_addr] : init_val(bram_addr);
      rd_pipe[0] <= w;
      for (int b = 0; b < BE_W; b++)
        if (bram_we[b]) w[8*b +: 8] = bram_din[8*b +: 8];
      if (bram_we != '0) begin
        bmem[bram_addr] <= w;
        bwr[bram_addr]  <= 1'b1;
      end
    end
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bram_dout = rd_pipe[RD_LAT-1];

  // ---------------- transaction-level reference model ----------------------
  typedef struct {
    int                due;
    bit                id;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              eq[$];
  bit [DATA_W-1:0]   sh_mem [4096];
  bit                sh_wr  [4096];
  int                cyc = 0;
  int                starve = 0;
  bit                pg = 0;
  logic [BE_W-1:0]   pwe = '0;
  logic [ADDR_W-1:0] paddr = '0;
  logic [DATA_W-1:0] pdin = '0;

  // One compare process: every falling edge, DUT outputs vs. the model.
  always @(negedge clk) begin : compare
    bit e_g0, e_g1, ev0, ev1, g_id;
    logic [DATA_W-1:0] ed, w;
    logic [ADDR_W-1:0] a;
    logic [BE_W-1:0]   we;
    cyc++;
    if (!rst_n) begin
      check("rst_gnt0", 32'(m0_gnt), 0);
      check("rst_gnt1", 32'(m1_gnt), 0);
      check("rst_nwait", 32'(fmc_nwait), 1);
      check("rst_en", 32'(bram_en), 0);
      check("rst_we", 32'(bram_we), 0);
      check("rst_addr", 32'(bram_addr), 0);
      check("rst_din", 32'(bram_din), 0);
      check("rst_rv0", 32'(m0_rvalid), 0);
      check("rst_rv1", 32'(m1_rvalid), 0);
      check("rst_rd0", 32'(m0_rdata), 0);
      check("rst_rd1", 32'(m1_rdata), 0);
      eq.delete();
      starve = 0; pg = 0; pwe = '0; paddr = '0; pdin = '0;
    end else begin
      e_g1 = m1_req && (!m0_req || starve >= STARVE_MAX);
      e_g0 = m0_req && !e_g1;
      check("gnt0", 32'(m0_gnt), 32'(e_g0));
      check("gnt1", 32'(m1_gnt), 32'(e_g1));
      check("nwait", 32'(fmc_nwait), 32'(!(m0_req && !e_g0)));
      check("bram_en", 32'(bram_en), 32'(pg));
      check("bram_we", 32'(bram_we), pg ? 32'(pwe) : 32'd0);
      check("bram_addr", 32'(bram_addr), 32'(paddr));
      check("bram_din", 32'(bram_din), 32'(pdin));
      ev0 = 0; ev1 = 0; ed = '0;
      if (eq.size() > 0 && eq[0].due == cyc) begin
        ev0 = (eq[0].id == 1'b0);
        ev1 = (eq[0].id == 1'b1);
        ed  = eq[0].data;
        void'(eq.pop_front());
      end
      check("rvalid0", 32'(m0_rvalid), 32'(ev0));
      check("rvalid1", 32'(m1_rvalid), 32'(ev1));
      if (ev0) check("rdata0", 32'(m0_rdata), 32'(ed));
      if (ev1) check("rdata1", 32'(m1_rdata), 32'(ed));
      // advance the model by this cycle's accepted command
      pg = e_g0 | e_g1;
      if (pg) begin
        g_id = e_g1;
        a    = g_id ? m1_addr  : m0_addr;
        we   = g_id ? m1_we    : m0_we;
        pwe  = we; paddr = a; pdin = g_id ? m1_wdata : m0_wdata;
        w    = sh_wr[a] ? sh_mem[a] : init_val(a);
        if (we == '0) begin
          eq.push_back('{due: cyc + RD_LAT + 1, id: g_id, data: w});
        end else begin
          for (int b = 0; b < BE_W; b++)
            if (we[b]) w[8*b +: 8] = pdin[8*b +: 8];
          sh_mem[a] = w;
          sh_wr[a]  = 1'b1;
        end
      end
      if (!m1_req || e_g1) starve = 0;
      else if (starve < STARVE_MAX) starve++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command and hold it until granted (bounded), then drop req.
  task automatic issue(input bit id, input logic [ADDR_W-1:0] a,
                       input logic [BE_W-1:0] we, input logic [DATA_W-1:0] d);
    bit done = 0;
    if (id) begin m1_req = 1; m1_addr = a; m1_we = we; m1_wdata = d; end
    else    begin m0_req = 1; m0_addr = a; m0_we = we; m0_wdata = d; end
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      done = id ? m1_gnt : m0_gnt;
      tick();
    end
    if (id) m1_req = 0; else m0_req = 0;
    check("issue_granted", 32'(done), 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stim
    bit g0, g1;
    // Reset with random request activity.
    for (int n = 0; n < 5; n++) begin
      m0_req = 1'($urandom); m1_req = 1'($urandom);
      m0_addr = 12'($urandom); m1_addr = 12'($urandom);
      tick();
    end
    m0_req = 0; m1_req = 0;
    rst_n = 1;
    tick(); tick();

    // First read after reset: enable one cycle later, data RD_LAT+1 later.
    issue(0, 12'h010, 2'b00, 16'h0);
    @(negedge clk);
    check("first_bram_en", 32'(bram_en), 1);
    check("first_bram_addr", 32'(bram_addr), 32'h010);
    repeat (RD_LAT) @(negedge clk);
    check("first_rvalid0", 32'(m0_rvalid), 1);
    check("first_rdata0", 32'(m0_rdata), 32'h5A10);
    tick(); tick();

    // Host write, internal read of the same word.
    issue(0, 12'h123, 2'b11, 16'hA5A5);
    issue(1, 12'h123, 2'b00, 16'h0);
    repeat (RD_LAT + 1) @(negedge clk);
    check("wr_rd_rvalid1", 32'(m1_rvalid), 1);
    check("wr_rd_rdata1", 32'(m1_rdata), 32'hA5A5);
    check("wr_rd_rvalid0", 32'(m0_rvalid), 0);
    tick(); tick();

    // Byte-enable merge.
    issue(1, 12'h200, 2'b11, 16'hFFFF);
    issue(0, 12'h200, 2'b10, 16'h1200);
    issue(0, 12'h200, 2'b00, 16'h0);
    repeat (RD_LAT + 1) @(negedge clk);
    check("be_rvalid0", 32'(m0_rvalid), 1);
    check("be_rdata0", 32'(m0_rdata), 32'h12FF);
    tick(); tick();

    // Starvation: both held for 20 cycles; requester 1 wins on cycles 9 and 18.
    m0_req = 1; m0_addr = 12'h300; m0_we = '0;
    m1_req = 1; m1_addr = 12'h301; m1_we = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("starve_gnt1", 32'(m1_gnt), 32'(k == 9 || k == 18));
      check("starve_nwait", 32'(fmc_nwait), 32'(!(k == 9 || k == 18)));
      tick();
    end
    m0_req = 0; m1_req = 0;
    repeat (RD_LAT + 3) tick();

    // Back-to-back alternating reads: returns 4 cycles after each grant, no gaps.
    for (int i = 0; i < 8 + RD_LAT + 1; i++) begin
      int j;
      m0_req = (i < 8) && (i % 2 == 0);
      m1_req = (i < 8) && (i % 2 == 1);
      m0_addr = 12'(12'h400 + i); m1_addr = 12'(12'h400 + i);
      m0_we = '0; m1_we = '0;
      @(negedge clk);
      if (i < 8) check("b2b_gnt", 32'((i % 2 == 1) ? m1_gnt : m0_gnt), 1);
      j = i - (RD_LAT + 1);
      if (j >= 0) begin
        check("b2b_rvalid", 32'((j % 2 == 1) ? m1_rvalid : m0_rvalid), 1);
        check("b2b_rdata", 32'((j % 2 == 1) ? m1_rdata : m0_rdata),
              32'(16'h5A00 ^ 16'(12'h400 + j)));
      end
      tick();
    end
    m0_req = 0; m1_req = 0;
    tick(); tick();

    // Reset one cycle after a read grant while requester 1 is being starved.
    m1_req = 1; m1_addr = 12'h050; m1_we = '0;
    issue(0, 12'h010, 2'b00, 16'h0);
    rst_n = 0; m1_req = 0;
    tick(); tick();
    rst_n = 1;
    @(negedge clk);
    check("midrst_starve", 32'(dut.starve_q), 0);
    for (int k = 0; k < RD_LAT + 3; k++) begin
      check("midrst_rvalid0", 32'(m0_rvalid), 0);
      @(negedge clk);
    end
    tick();

    // Randomized traffic with requesters obeying the hold-until-granted rule.
    g0 = 0; g1 = 0;
    for (int n = 0; n < 400; n++) begin
      if (!(m0_req && !g0)) begin
        m0_req = ($urandom % 4) != 0;
        m0_addr = 12'($urandom % 16);
        m0_we = ($urandom % 2) ? 2'($urandom) : 2'b00;
        m0_wdata = 16'($urandom);
      end
      if (!(m1_req && !g1)) begin
        m1_req = ($urandom % 3) != 0;
        m1_addr = 12'($urandom % 16);
        m1_we = ($urandom % 2) ? 2'($urandom) : 2'b00;
        m1_wdata = 16'($urandom);
      end
      @(negedge clk);
      g0 = m0_gnt; g1 = m1_gnt;
      tick();
    end
    m0_req = 0; m1_req = 0;
    repeat (RD_LAT + 4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
